// File: rtl/mux_pkg.sv
// Shared constants and types for the N-to-1 registered round-robin multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mux_nto1_rr_rr_pick.sv
// Round-robin picker: rotates the request vector to start at ptr and
// priority-encodes the first set bit back into an absolute channel index.
module rr_pick #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_vld
);

    localparam int IW = SELW + 1;

    logic [IW-1:0]   w_sum [N];
    logic [SELW-1:0] w_idx [N];
    logic [N-1:0]    w_rot;

    // ptr is always < N, so one conditional subtract implements the modulo.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign w_sum[gi] = {1'b0, ptr} + IW'(gi);
            assign w_idx[gi] = (w_sum[gi] >= IW'(N)) ? SELW'(w_sum[gi] - IW'(N))
                                                     : SELW'(w_sum[gi]);
            assign w_rot[gi] = req[w_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        grant     = '0;
        grant_vld = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                grant = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 multiplexer with per-channel valid/ready, a one-entry output register
// with backpressure, and fixed-select or round-robin channel selection.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  In,
    input  logic [N-1:0]    In_valid,
    output logic [N-1:0]    In_ready,
    input  logic [SELW-1:0] Sel,
    input  logic            Mode,
    output logic [W-1:0]    out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_sel
);

    localparam int PADN = 1 << SELW;

    out_state_e      r_state;
    out_state_e      w_state_next;
    logic [W-1:0]    r_out;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_next;

    logic [W-1:0]    w_ch [N];
    logic [PADN-1:0] w_valid_pad;
    logic [SELW-1:0] w_rr_grant;
    logic            w_rr_vld;
    logic [SELW-1:0] w_grant;
    logic            w_grant_vld;
    logic            w_load;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign w_ch[gi]     = In[gi*W +: W];
            assign In_ready[gi] = !rst && w_load && (w_grant == SELW'(gi));
        end
    endgenerate

    // Zero padding up to 2**SELW makes an out-of-range Sel read as "not valid".
    assign w_valid_pad = PADN'(In_valid);

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .req       (In_valid),
        .ptr       (r_ptr),
        .grant     (w_rr_grant),
        .grant_vld (w_rr_vld)
    );

    always_comb begin
        w_grant      = Sel;
        w_grant_vld  = w_valid_pad[Sel];
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        if (Mode == MODE_RR) begin
            w_grant     = w_rr_grant;
            w_grant_vld = w_rr_vld;
        end
        w_load = ((r_state == OUT_EMPTY) || out_ready) && w_grant_vld;
        if (w_load) begin
            w_state_next = OUT_FULL;
        end else if (out_ready) begin
            w_state_next = OUT_EMPTY;
        end
        if (w_load && (Mode == MODE_RR)) begin
            w_ptr_next = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
            r_out   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            if (w_load) begin
                r_out <= w_ch[w_grant];
                r_sel <= w_grant;
            end
        end
    end

    assign out       = r_out;
    assign out_sel   = r_sel;
    assign out_valid = (r_state == OUT_FULL);

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mux_nto1_rr;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  In;
    logic [N-1:0]    In_valid;
    logic [N-1:0]    In_ready;
    logic [SELW-1:0] Sel;
    logic            Mode;
    logic [W-1:0]    out;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_sel;

    // Three-channel instance for the out-of-range select case.
    logic [3*W-1:0]  In3;
    logic [2:0]      In_valid3;
    logic [2:0]      In_ready3;
    logic [1:0]      Sel3;
    logic            Mode3;
    logic [W-1:0]    out3;
    logic            out_valid3;
    logic            out_ready3;
    logic [1:0]      out_sel3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0]    m_out;
    logic [SELW-1:0] m_sel;
    logic [SELW-1:0] m_ptr;
    logic            m_valid;

    always #5 clk = ~clk;

    mux_nto1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .In        (In),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Sel       (Sel),
        .Mode      (Mode),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    mux_nto1_rr #(.N(3), .W(W)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .In        (In3),
        .In_valid  (In_valid3),
        .In_ready  (In_ready3),
        .Sel       (Sel3),
        .Mode      (Mode3),
        .out       (out3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_sel   (out_sel3)
    );

    function automatic void model_pick(output logic gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (Mode == 1'b0) begin
            if (int'(Sel) < N && In_valid[Sel]) begin
                gv = 1'b1;
                g  = int'(Sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % N;
                if (!gv && In_valid[idx]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic          gv;
        int            g;
        logic [N-1:0]  r;
        r = '0;
        model_pick(gv, g);
        if (!rst && (!m_valid || out_ready) && gv) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_ch(input int i, input logic [W-1:0] d);
        In[i*W +: W] = d;
    endtask

    // Advance one clock and update the reference model from the pre-edge inputs.
    task automatic tick();
        logic         gv;
        int           g;
        logic         ld;
        logic [W-1:0] nd;
        model_pick(gv, g);
        ld = !rst && (!m_valid || out_ready) && gv;
        nd = In[g*W +: W];
        @(posedge clk);
        #1;
        if (rst) begin
            m_out = '0; m_sel = '0; m_valid = 1'b0; m_ptr = '0;
        end else if (ld) begin
            m_out   = nd;
            m_sel   = SELW'(g);
            m_valid = 1'b1;
            if (Mode) m_ptr = SELW'((g + 1) % N);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        In_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (In_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", In_ready);
        end
        tick();
        tick();
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got out=%h v=%b sel=%0d expected 00/0/0", out, out_valid, out_sel);
        end
        rst = 1'b0;
        In_valid = '0;
        #1;
        $display("test_reset: out=%h out_valid=%b", out, out_valid);
    endtask

    task automatic test_fixed();
        Mode = 1'b0; Sel = 2'd2; In_valid = 4'b0100; out_ready = 1'b1;
        set_ch(2, 8'hA5);
        #1;
        n_checks++;
        if (In_ready !== 4'b0100) begin
            n_fail++; $display("FAIL fixed_ready: got %b expected 0100", In_ready);
        end
        tick();
        n_checks++;
        if (out !== 8'hA5 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_out: got out=%h sel=%0d v=%b expected a5/2/1", out, out_sel, out_valid);
        end
        In_valid = '0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out !== 8'hA5) begin
            n_fail++; $display("FAIL fixed_drain: got v=%b out=%h expected 0/a5", out_valid, out);
        end
        $display("test_fixed: out=%h out_sel=%0d", out, out_sel);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        Mode = 1'b0; Sel = 2'd1; In_valid = 4'b0010; out_ready = 1'b1;
        set_ch(1, 8'h11);
        #1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            d = W'($urandom_range(8'h20, 8'hFF));
            set_ch(1, d);
            #1;
            n_checks++;
            if (In_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready: got %b expected 0000", In_ready);
            end
            tick();
            n_checks++;
            if (out !== 8'h11 || out_valid !== 1'b1 || out_sel !== 2'd1) begin
                n_fail++; $display("FAIL bp_hold: got out=%h v=%b expected 11/1", out, out_valid);
            end
        end
        set_ch(1, 8'h5C);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (In_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", In_ready);
        end
        tick();
        n_checks++;
        if (out !== 8'h5C || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_out: got out=%h v=%b expected 5c/1", out, out_valid);
        end
        In_valid = '0;
        tick();
        $display("test_backpressure: out=%h", out);
    endtask

    task automatic test_rr_fairness();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        Mode = 1'b1; In_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, W'(8'h40 + i));
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (int'(out_sel) !== exp_seq[i] || out !== W'(8'h40 + exp_seq[i]) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_fair[%0d]: got sel=%0d out=%h expected sel=%0d out=%h",
                         i, out_sel, out, exp_seq[i], 8'h40 + exp_seq[i]);
            end
        end
        In_valid = '0;
        tick();
        $display("test_rr_fairness: last out_sel=%0d", out_sel);
    endtask

    task automatic test_rr_skip();
        // Pointer is 2 here; a lone request on channel 0 moves it to 1.
        Mode = 1'b1; In_valid = 4'b0001; out_ready = 1'b1;
        #1;
        tick();
        In_valid = 4'b1001;
        #1;
        n_checks++;
        if (In_ready !== 4'b1000) begin
            n_fail++; $display("FAIL rr_skip_ready3: got %b expected 1000", In_ready);
        end
        tick();
        n_checks++;
        if (out_sel !== 2'd3) begin
            n_fail++; $display("FAIL rr_skip_sel3: got %0d expected 3", out_sel);
        end
        n_checks++;
        if (In_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rr_skip_ready0: got %b expected 0001", In_ready);
        end
        tick();
        n_checks++;
        if (out_sel !== 2'd0) begin
            n_fail++; $display("FAIL rr_skip_sel0: got %0d expected 0", out_sel);
        end
        In_valid = '0;
        tick();
        $display("test_rr_skip: out_sel=%0d", out_sel);
    endtask

    task automatic test_out_of_range();
        Mode3 = 1'b0; Sel3 = 2'd3; In_valid3 = 3'b111; out_ready3 = 1'b1;
        In3 = {8'hC2, 8'hB1, 8'hA0};
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (In_ready3 !== 3'b000) begin
                n_fail++; $display("FAIL oor_ready: got %b expected 000", In_ready3);
            end
            tick();
            n_checks++;
            if (out_valid3 !== 1'b0) begin
                n_fail++; $display("FAIL oor_valid: got %b expected 0", out_valid3);
            end
        end
        Sel3 = 2'd2;
        #1;
        n_checks++;
        if (In_ready3 !== 3'b100) begin
            n_fail++; $display("FAIL n3_ready: got %b expected 100", In_ready3);
        end
        tick();
        n_checks++;
        if (out3 !== 8'hC2 || out_sel3 !== 2'd2 || out_valid3 !== 1'b1) begin
            n_fail++; $display("FAIL n3_out: got out=%h sel=%0d v=%b expected c2/2/1", out3, out_sel3, out_valid3);
        end
        In_valid3 = '0;
        tick();
        $display("test_out_of_range: out_valid3=%b", out_valid3);
    endtask

    task automatic test_reset_full();
        Mode = 1'b1; In_valid = 4'b0100; out_ready = 1'b1;
        set_ch(2, 8'h77);
        #1;
        tick();
        out_ready = 1'b0;
        In_valid = 4'b1111;
        rst = 1'b1;
        #1;
        n_checks++;
        if (In_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstfull_ready: got %b expected 0000", In_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== 8'h00 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rstfull_state: got v=%b out=%h sel=%0d expected 0/00/0", out_valid, out, out_sel);
        end
        n_checks++;
        if (In_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstfull_ptr: got ready=%b expected 0001", In_ready);
        end
        out_ready = 1'b1;
        tick();
        In_valid = '0;
        tick();
        $display("test_reset_full: out_sel=%0d", out_sel);
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int c = 0; c < 400; c++) begin
            Mode      = 1'($urandom_range(0, 1));
            Sel       = SELW'($urandom);
            In_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) set_ch(i, W'($urandom));
            #1;
            er = exp_ready();
            n_checks++;
            if (In_ready !== er) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, In_ready, er);
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid || out !== m_out || out_sel !== m_sel) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b out=%h sel=%0d expected v=%b out=%h sel=%0d",
                         c, out_valid, out, out_sel, m_valid, m_out, m_sel);
            end
        end
        rst = 1'b0;
        In_valid = '0;
        $display("test_random: 400 cycles");
    endtask

    initial begin
        rst = 1'b1; In = '0; In_valid = '0; Sel = '0; Mode = 1'b0; out_ready = 1'b0;
        In3 = '0; In_valid3 = '0; Sel3 = '0; Mode3 = 1'b0; out_ready3 = 1'b0;
        m_out = '0; m_sel = '0; m_ptr = '0; m_valid = 1'b0;
        test_reset();
        test_fixed();
        test_backpressure();
        test_rr_fairness();
        test_rr_skip();
        test_out_of_range();
        test_reset_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
